// File: rtl/row_clear_ctrl_if.sv
// ============================================================================
// Module  : row_clear_ctrl_if
// Purpose : Control handshake and board-RAM port bundle for row_clear_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface row_clear_ctrl_if #(
  parameter int COLS = 10,
  parameter int AW   = 4,
  parameter int CW   = 5
) ();
  logic            start;
  logic            busy;
  logic            done;
  logic [CW-1:0]   cleared_count;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;

  modport slave (
    input  start, rd_data,
    output busy, done, cleared_count, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, rd_data,
    input  busy, done, cleared_count, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/row_clear_ctrl.sv
// ============================================================================
// Module  : row_clear_ctrl
// Purpose : Bottom-up line-clear sequencer; compacts surviving rows in place.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module row_clear_ctrl #(
  parameter int ROWS = 16,
  parameter int COLS = 10,
  parameter int AW   = 4,
  parameter int CW   = 5
) (
  input  wire                clka,
  input  wire                restart_n,
  row_clear_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] c_LAST_ROW = AW'(ROWS - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_rp, w_rp_nxt;
  logic [AW-1:0] r_wp, w_wp_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_cleared, w_cleared_nxt;

  logic            w_full;
  logic            w_wr_en;
  logic [COLS-1:0] w_wr_data;
  logic            w_done;

  assign w_full = &bus.rd_data;

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      r_state   <= S_IDLE;
      r_rp      <= c_LAST_ROW;
      r_wp      <= c_LAST_ROW;
      r_cnt     <= '0;
      r_cleared <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rp      <= w_rp_nxt;
      r_wp      <= w_wp_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cleared <= w_cleared_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rp_nxt      = r_rp;
    w_wp_nxt      = r_wp;
    w_cnt_nxt     = r_cnt;
    w_cleared_nxt = r_cleared;
    w_wr_en       = 1'b0;
    w_wr_data     = '0;
    w_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_rp_nxt    = c_LAST_ROW;
          w_wp_nxt    = c_LAST_ROW;
          w_cnt_nxt   = '0;
          w_state_nxt = S_READ;
        end
      end
      S_READ: w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_full) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          // Survivors always land at or below the row just read, so this
          // never overwrites an unread row.
          w_wr_en   = 1'b1;
          w_wr_data = bus.rd_data;
          if (r_wp != '0) w_wp_nxt = r_wp - AW'(1);
        end
        if (r_rp != '0) begin
          w_rp_nxt    = r_rp - AW'(1);
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = (w_cnt_nxt != '0) ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        w_wr_en = 1'b1;
        if (r_wp == '0) w_state_nxt = S_DONE;
        else            w_wp_nxt    = r_wp - AW'(1);
      end
      S_DONE: begin
        w_done        = 1'b1;
        w_cleared_nxt = r_cnt;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = w_done;
  assign bus.cleared_count = r_cleared;
  assign bus.rd_addr       = r_rp;
  assign bus.wr_en         = w_wr_en;
  assign bus.wr_addr       = r_wp;
  assign bus.wr_data       = w_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_row_clear_ctrl.sv
// ============================================================================
// Module  : tb_row_clear_ctrl
// Purpose : Scoreboard bench for row_clear_ctrl with a behavioural board RAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_row_clear_ctrl;
  localparam int ROWS = 16;
  localparam int COLS = 10;
  localparam int AW   = 4;
  localparam int CW   = 5;
  localparam logic [COLS-1:0] FULL = 10'h3FF;

  logic clka = 1'b0;
  logic restart_n = 1'b0;
  always #5 clka = ~clka;

  row_clear_ctrl_if #(.COLS(COLS), .AW(AW), .CW(CW)) bus ();

  row_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .CW(CW)) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .bus       (bus)
  );

  // Board RAM: synchronous read, one-cycle latency
  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] rd_q = '0;
  assign bus.rd_data = rd_q;
  always @(posedge clka) begin
    rd_q <= mem[bus.rd_addr];
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0]   a;
    logic [COLS-1:0] d;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_lat[$];
  int  exp_cnt[$];

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  bit mon_en = 1'b0;
  bit pend_cnt = 1'b0;
  int pend_val = 0;

  logic [COLS-1:0] init_b [ROWS];
  logic [COLS-1:0] fin_b  [ROWS];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done
  always @(negedge clka) begin
    if (mon_en) begin
      if (pend_cnt) begin
        chk("cleared_count", int'(bus.cleared_count), pend_val);
        chk("busy_after_done", int'(bus.busy), 0);
        pend_cnt = 1'b0;
      end
      if (bus.wr_en) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", int'(bus.wr_addr), -1);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", int'(bus.wr_addr), int'(e.a));
          chk("wr_data", int'(bus.wr_data), int'(e.d));
        end
      end
      if (bus.done) begin
        if (exp_lat.size() == 0) begin
          chk("unexpected_done", cyc - start_cyc, -1);
        end else begin
          chk("done_latency", cyc - start_cyc, exp_lat.pop_front());
          pend_val = exp_cnt.pop_front();
          pend_cnt = 1'b1;
        end
      end
    end
  end

  // Expected writes: surviving rows compacted bottom-up, then zero fill
  task automatic push_model();
    int wp = ROWS - 1;
    int k = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (init_b[r] == FULL) k++;
      else begin
        exp_wr.push_back('{a: AW'(wp), d: init_b[r]});
        wp--;
      end
    end
    for (int i = 0; i < k; i++) begin
      exp_wr.push_back('{a: AW'(wp), d: '0});
      wp--;
    end
  endtask

  task automatic run(input int lat, input int k, input bit dbl);
    for (int r = 0; r < ROWS; r++) mem[r] = init_b[r];
    push_model();
    exp_lat.push_back(lat);
    exp_cnt.push_back(k);
    @(posedge clka); #1;
    bus.start = 1'b1;
    start_cyc = cyc;
    for (int c = 1; c < 120; c++) begin
      @(posedge clka); #1;
      bus.start = dbl && (c == 5 || c == lat);
      if (exp_lat.size() == 0 && c > lat + 4) break;
    end
    bus.start = 1'b0;
    if (exp_lat.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_lat.delete();
      exp_cnt.delete();
    end
    chk("writes_remaining", exp_wr.size(), 0);
    exp_wr.delete();
    if (dbl) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clka);
        chk("busy_stays_low", int'(bus.busy), 0);
      end
    end
    for (int r = 0; r < ROWS; r++) chk($sformatf("board_row%0d", r), int'(mem[r]), int'(fin_b[r]));
  endtask

  task automatic setup_t2();
    for (int r = 0; r < ROWS; r++) begin init_b[r] = '0; fin_b[r] = '0; end
    init_b[15] = FULL; init_b[14] = 10'h001;
    fin_b[15]  = 10'h001;
  endtask

  initial begin
    bus.start = 1'b0;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_cleared", int'(bus.cleared_count), 0);
    chk("rst_rd_addr", int'(bus.rd_addr), ROWS - 1);
    restart_n = 1'b1;
    mon_en = 1'b1;

    // Empty board
    for (int r = 0; r < ROWS; r++) begin init_b[r] = '0; fin_b[r] = '0; end
    run(33, 0, 1'b0);

    // Single full row at the bottom
    setup_t2();
    run(34, 1, 1'b0);

    // Interleaved full rows, with stray starts mid-run and on done
    for (int r = 0; r < ROWS; r++) begin init_b[r] = '0; fin_b[r] = '0; end
    init_b[15] = FULL; init_b[13] = FULL; init_b[11] = FULL; init_b[9] = FULL;
    init_b[14] = 10'h155; init_b[12] = 10'h2AA;
    fin_b[15] = 10'h155; fin_b[14] = 10'h2AA;
    run(37, 4, 1'b1);

    // Every row full
    for (int r = 0; r < ROWS; r++) begin init_b[r] = FULL; fin_b[r] = '0; end
    run(49, 16, 1'b0);

    // Mid-run reset
    mon_en = 1'b0;
    setup_t2();
    for (int r = 0; r < ROWS; r++) mem[r] = init_b[r];
    @(posedge clka); #1;
    bus.start = 1'b1;
    @(posedge clka); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clka);
    #1 restart_n = 1'b0;
    @(posedge clka);
    @(negedge clka);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_cleared", int'(bus.cleared_count), 0);
    restart_n = 1'b1;
    pend_cnt = 1'b0;
    mon_en = 1'b1;
    run(34, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1);
  end
endmodule

`default_nettype wire

// File: doc/row_clear_ctrl.md
# row_clear_ctrl

Line-clear sequencer for the Tetris board store. It is launched by the main game controller after a piece lands and scans the board RAM from the bottom row to the top. Full rows are removed by compacting the surviving rows downward in place, and the vacated top rows are zero-filled. It reports completion and the number of rows cleared, which feed scoring and the return to piece generation.

## Interface
Parameters:
- ROWS, 16: board height in rows; row 0 is the top, row ROWS-1 is the bottom.
- COLS, 10: board width; one bit per cell, 1 means occupied.
- AW, 4: row address width; must satisfy 2^AW >= ROWS.
- CW, 5: cleared-count width; must satisfy 2^CW > ROWS.

Ports:
- clka, input, 1: the single clock; all state changes on its rising edge.
- restart_n, input, 1: reset, synchronous, active-low.
- start, input, 1: one-cycle request from the main controller; honoured only in IDLE.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the board is consistent again.
- cleared_count, output, CW: number of full rows removed by the last run.
- rd_addr, output, AW: board RAM read address.
- rd_data, input, COLS: board RAM read data; synchronous RAM with 1-cycle latency.
- wr_en, output, 1: board RAM write enable.
- wr_addr, output, AW: board RAM write address.
- wr_data, output, COLS: board RAM write data.

## Operation
- Internal registers: state, rp (read row), wp (write row), cnt (count of cleared rows).
- States: IDLE, READ, CHECK, FILL, DONE.
- IDLE
  - On start=1: rp<=ROWS-1, wp<=ROWS-1, cnt<=0, go to READ.
  - Otherwise stay in IDLE.
- READ
  - Drive rd_addr=rp, then go to CHECK.
- CHECK
  - rd_data holds row rp.
  - Full row (rd_data all ones): cnt<=cnt+1 and no write.
  - Not full: wr_en=1, wr_addr=wp, wr_data=rd_data, then wp<=wp-1.
  - A write is issued even when wp==rp; identity writes are legal.
  - If rp!=0: rp<=rp-1 and go to READ.
  - If rp==0: go to FILL when the updated cnt>0, else go to DONE.
- FILL
  - Drive wr_en=1, wr_addr=wp, wr_data=0.
  - If wp==0, go to DONE; otherwise wp<=wp-1.
  - Exactly cnt rows are written.
- DONE
  - done=1 and cleared_count<=cnt, then go to IDLE.
- Outputs are decoded combinationally from the registered state and pointers.
- wr_en is 0 in IDLE, READ and DONE.
- rd_addr equals rp in every state; it is meaningful only in READ.
- cleared_count holds its value until the next DONE.
- start is ignored while busy=1; there is no queueing.
- Arithmetic:
  - wp and rp never decrement below 0; the transitions above prevent it.
  - cnt ranges 0..ROWS; cnt=ROWS means every row was full.

## Timing
- Reset (restart_n=0 at an edge): state=IDLE, rp=wp=ROWS-1, cnt=0, cleared_count=0.
- Reset outputs: busy=0, done=0, wr_en=0.
- Reset applied mid-run aborts immediately. Board contents are whatever was written so far; the caller re-initialises the board on restart.
- Cycle-level sequence, with start high in cycle t:
  - Cycle t+1: READ for row ROWS-1.
  - Cycle t+2: its CHECK.
  - Cycle t+2i+1 / t+2i+2: READ / CHECK of row ROWS-1-i.
- With k rows cleared:
  - FILL occupies cycles t+2*ROWS+1 .. t+2*ROWS+k.
  - done is high in cycle t+2*ROWS+k+1 and busy drops the cycle after.
  - Latency from start to done is 2*ROWS+k+1 cycles: 33 with k=0 and 37 with k=4 at ROWS=16.
- Read-before-write safety: wp>=rp always holds. A write therefore never targets a row that has not yet been read.
- A start arriving in the same cycle as done (state DONE) is ignored. A new start is accepted one cycle after done.

## Test plan
- Empty board, start pulse:
  - 16 writes of 0 to rows 15..0, no FILL.
  - done at start+33, cleared_count=0.
- Row 15 = 0x3FF, row 14 = 0x001, all others 0:
  - Final row 15=0x001 and rows 14..0=0.
  - Exactly one FILL write, to row 0.
  - done at start+34, cleared_count=1.
- Rows 15, 13, 11, 9 = 0x3FF; row 14 = 0x155; row 12 = 0x2AA; rows 10 and 8..0 = 0:
  - Final row 15=0x155, row 14=0x2AA, rows 13..0 all 0.
  - done at start+37, cleared_count=4.
- All 16 rows = 0x3FF:
  - No CHECK writes, 16 FILL writes of 0.
  - Board all zero, done at start+49, cleared_count=16.
- Second start pulse mid-run (cycle start+5) and a start coinciding with done:
  - Both ignored; trace identical to a single run, and busy never re-rises without a fresh start.
- restart_n=0 at start+10:
  - Next cycle busy=0, wr_en=0, cleared_count=0.
  - A subsequent start runs normally from row 15.
